// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared command codes, FSM states and I/O window addresses for mem_responder
package mem_pkg;

  localparam logic [1:0] MEM_NONE    = 2'b00;
  localparam logic [1:0] MEM_READ    = 2'b01;
  localparam logic [1:0] MEM_WRITE   = 2'b10;
  localparam logic [1:0] MEM_ILLEGAL = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } mem_state_t;

  localparam logic [8:0] SW_ADDR_DEF  = 9'h100;
  localparam logic [8:0] LED_ADDR_DEF = 9'h140;

endpackage

// File: rtl/ram_1p.sv
// rtl/ram_1p.sv - single-port RAM, synchronous write, registered read held while re is low
module ram_1p #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately unreset; the owner clears them with a sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU memory responder: cleared RAM plus switch/LED I/O window
module mem_responder
  import mem_pkg::*;
#(
  parameter int         DEPTH    = 256,
  parameter logic [8:0] SW_ADDR  = SW_ADDR_DEF,
  parameter logic [8:0] LED_ADDR = LED_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_ack,
  output logic        ready,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        cmd_err
);

  localparam logic [8:0] CLR_LAST = 9'(DEPTH - 1);

  mem_state_t  state;
  logic [8:0]  clr_idx;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [15:0] io_data;
  logic        src_ram;
  logic [15:0] ram_q;

  logic        do_read;
  logic        do_write;
  logic        illegal;
  logic        is_ram;
  logic        is_sw;
  logic        is_led;
  logic        ram_we;
  logic        ram_re;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;

  assign is_ram = ~mem_addr[8];
  assign is_sw  = (mem_addr == SW_ADDR);
  assign is_led = (mem_addr == LED_ADDR);

  always_comb begin
    do_read  = 1'b0;
    do_write = 1'b0;
    illegal  = 1'b0;
    if (ready) begin
      case (mem_cmd)
        MEM_NONE:  ;
        MEM_READ:  do_read  = 1'b1;
        MEM_WRITE: do_write = 1'b1;
        default:   illegal  = 1'b1;
      endcase
    end
  end

  // The clear sweep owns the RAM write port until the FSM reaches IDLE.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = mem_addr[7:0];
    ram_wdata = write_data;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_addr  = clr_idx[7:0];
      ram_wdata = 16'h0000;
    end else if (do_write && is_ram) begin
      ram_we = 1'b1;
    end
  end

  assign ram_re = do_read & is_ram;

  ram_1p #(
    .DEPTH (DEPTH),
    .AW    (8),
    .DW    (16)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta <= 8'h00;
      sw_sync <= 8'h00;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= INIT;
      clr_idx <= 9'd0;
      ready   <= 1'b0;
      led     <= 8'h00;
      cmd_err <= 1'b0;
      mem_ack <= 1'b0;
      io_data <= 16'h0000;
      src_ram <= 1'b0;
    end else begin
      mem_ack <= do_read | do_write;
      if (illegal) begin
        cmd_err <= 1'b1;
      end
      if (do_write && is_led) begin
        led <= write_data[7:0];
      end
      // Non-RAM reads are captured here; RAM reads come from the RAM's own output register.
      if (do_read) begin
        src_ram <= is_ram;
        io_data <= is_sw ? {8'h00, sw_sync} : 16'h0000;
      end
      case (state)
        INIT: begin
          clr_idx <= clr_idx + 9'd1;
          if (clr_idx == CLR_LAST) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: ready <= 1'b1;
      endcase
    end
  end

  assign read_data = src_ram ? ram_q : io_data;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;
  import mem_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ack;
  logic        ready;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        cmd_err;

  mem_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_ack    (mem_ack),
    .ready      (ready),
    .sw         (sw),
    .led        (led),
    .cmd_err    (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_mem [256];
  logic [15:0] m_rd;
  logic        m_ack;
  logic [7:0]  m_led;
  logic        m_err;
  logic [7:0]  sw_e1;
  logic [7:0]  sw_e2;

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    logic        ack;
    logic [7:0]  led;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    logic [7:0] sync_now;
    sync_now = sw_e2;
    sw_e2 = sw_e1;
    sw_e1 = sw;
    m_ack = 1'b0;
    case (c)
      2'b01: begin
        m_ack = 1'b1;
        if (!a[8]) m_rd = m_mem[a[7:0]];
        else if (a == 9'h100) m_rd = {8'h00, sync_now};
        else m_rd = 16'h0000;
      end
      2'b10: begin
        m_ack = 1'b1;
        if (!a[8]) m_mem[a[7:0]] = d;
        else if (a == 9'h140) m_led = d[7:0];
      end
      2'b11: m_err = 1'b1;
      default: ;
    endcase
  endtask

  task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
    model_step(c, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit noisy, output int n, output bit saw_ack);
    n = 0;
    saw_ack = 1'b0;
    while (n < 400) begin
      if (noisy) begin
        mem_cmd    = 2'($urandom_range(0, 3));
        mem_addr   = ($urandom_range(0, 3) == 0) ? 9'h140 : 9'($urandom_range(0, 31));
        write_data = 16'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
      if (mem_ack) saw_ack = 1'b1;
      if (ready) break;
    end
    mem_cmd = MEM_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw_ack;
    logic [1:0]  c;
    logic [8:0]  a;
    logic [15:0] d;
    int  r;

    reset_n    = 1'b0;
    mem_cmd    = MEM_NONE;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
    sw         = 8'hA5;

    tbl.push_back('{MEM_READ,    9'h005, 16'h0000, 16'h0000, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{MEM_NONE,    9'h005, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{MEM_WRITE,   9'h010, 16'hD107, 16'h0000, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{MEM_READ,    9'h010, 16'h0000, 16'hD107, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{MEM_NONE,    9'h010, 16'h0000, 16'hD107, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{MEM_WRITE,   9'h140, 16'h1234, 16'hD107, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_READ,    9'h140, 16'h0000, 16'h0000, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_READ,    9'h100, 16'h0000, 16'h00A5, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_WRITE,   9'h100, 16'hFFFF, 16'h00A5, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_WRITE,   9'h1FF, 16'hBEEF, 16'h00A5, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_READ,    9'h1FF, 16'h0000, 16'h0000, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_READ,    9'h0FF, 16'h0000, 16'h0000, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_WRITE,   9'h000, 16'h0007, 16'h0000, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_WRITE,   9'h001, 16'h0002, 16'h0000, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_WRITE,   9'h002, 16'h0009, 16'h0000, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_WRITE,   9'h003, 16'h0009, 16'h0000, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_READ,    9'h000, 16'h0000, 16'h0007, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_READ,    9'h001, 16'h0000, 16'h0002, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_READ,    9'h002, 16'h0000, 16'h0009, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_READ,    9'h003, 16'h0000, 16'h0009, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{MEM_ILLEGAL, 9'h000, 16'hFFFF, 16'h0009, 1'b0, 8'h34, 1'b1});
    tbl.push_back('{MEM_READ,    9'h000, 16'h0000, 16'h0007, 1'b1, 8'h34, 1'b1});
    tbl.push_back('{MEM_NONE,    9'h000, 16'h0000, 16'h0007, 1'b0, 8'h34, 1'b1});
    tbl.push_back('{MEM_ILLEGAL, 9'h140, 16'h5555, 16'h0007, 1'b0, 8'h34, 1'b1});

    repeat (3) @(posedge clk);
    #1;
    chk("reset read_data", 32'(read_data), 32'h0);
    chk("reset mem_ack",   32'(mem_ack),   32'h0);
    chk("reset ready",     32'(ready),     32'h0);
    chk("reset led",       32'(led),       32'h0);
    chk("reset cmd_err",   32'(cmd_err),   32'h0);

    reset_n = 1'b1;
    wait_ready(1'b1, n, saw_ack);
    chk("sweep length", 32'(n), 32'd256);
    chk("init ack ignored", 32'(saw_ack), 32'h0);
    chk("init led ignored", 32'(led), 32'h0);
    chk("init cmd_err ignored", 32'(cmd_err), 32'h0);

    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
    m_rd  = 16'h0000;
    m_ack = 1'b0;
    m_led = 8'h00;
    m_err = 1'b0;
    sw_e1 = sw;
    sw_e2 = sw;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cmd, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("vec%0d read_data", i), 32'(read_data), 32'(tbl[i].rd));
      chk($sformatf("vec%0d mem_ack", i),   32'(mem_ack),   32'(tbl[i].ack));
      chk($sformatf("vec%0d led", i),       32'(led),       32'(tbl[i].led));
      chk($sformatf("vec%0d cmd_err", i),   32'(cmd_err),   32'(tbl[i].err));
      chk($sformatf("vec%0d ready", i),     32'(ready),     32'h1);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 6)      a = 9'($urandom_range(0, 15));
      else if (r == 7) a = 9'h100;
      else if (r == 8) a = 9'h140;
      else             a = {1'b1, 8'($urandom)};
      r = $urandom_range(0, 15);
      if (r <= 5)       c = MEM_READ;
      else if (r <= 11) c = MEM_WRITE;
      else if (r <= 14) c = MEM_NONE;
      else              c = MEM_ILLEGAL;
      d = 16'($urandom);
      drive(c, a, d);
      chk($sformatf("rnd%0d read_data", i), 32'(read_data), 32'(m_rd));
      chk($sformatf("rnd%0d mem_ack", i),   32'(mem_ack),   32'(m_ack));
      chk($sformatf("rnd%0d led", i),       32'(led),       32'(m_led));
      chk($sformatf("rnd%0d cmd_err", i),   32'(cmd_err),   32'(m_err));
      chk($sformatf("rnd%0d ready", i),     32'(ready),     32'h1);
    end

    drive(MEM_WRITE, 9'h140, 16'h005A);
    chk("pre-reset led", 32'(led), 32'h5A);
    mem_cmd = MEM_NONE;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset ready",     32'(ready),     32'h0);
    chk("async reset led",       32'(led),       32'h0);
    chk("async reset read_data", 32'(read_data), 32'h0);
    chk("async reset mem_ack",   32'(mem_ack),   32'h0);
    chk("async reset cmd_err",   32'(cmd_err),   32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("mid-sweep ready", 32'(ready), 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mid-sweep reset ready", 32'(ready), 32'h0);
    chk("mid-sweep reset led",   32'(led),   32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_ready(1'b0, n, saw_ack);
    chk("restarted sweep length", 32'(n), 32'd256);
    drive(MEM_READ, 9'h010, 16'h0000);
    chk("post-sweep cleared word", 32'(read_data), 32'h0);
    chk("post-sweep ack",          32'(mem_ack),   32'h1);
    drive(MEM_NONE, 9'h010, 16'h0000);
    chk("post-sweep ack drops",    32'(mem_ack),   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
